// File: rtl/uart_rx.sv
// uart_rx: UART receiver with 2-flop input synchronizer, mid-bit sampling and framing-error detection
// Ports:
//   clk            rising-edge clock
//   reset          synchronous active-high reset
//   i_serial_data  asynchronous serial line, idle high
//   o_rx_data      last correctly received payload
//   o_rx_done      one-cycle pulse when o_rx_data updates
//   o_rx_busy      high while a frame is being received
//   o_frame_err    one-cycle pulse on a bad stop bit
module uart_rx #(
  parameter int BIT_RATE     = 115200,
  parameter int CLK_FREQ     = 10_000_000,
  parameter int PAYLOAD_BITS = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_serial_data,
  output logic [PAYLOAD_BITS-1:0] o_rx_data,
  output logic                    o_rx_done,
  output logic                    o_rx_busy,
  output logic                    o_frame_err
);
  localparam int CYCLES_PER_BIT = CLK_FREQ / BIT_RATE;
  localparam int HALF_BIT       = CYCLES_PER_BIT / 2;
  localparam int CW             = $clog2(CYCLES_PER_BIT) + 1;
  localparam int IW             = $clog2(PAYLOAD_BITS) + 1;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
  state_t                  r_state;
  logic [1:0]              r_sync;
  logic [CW-1:0]           r_cnt;
  logic [IW-1:0]           r_idx;
  logic [PAYLOAD_BITS-1:0] r_shift;
  logic                    w_rx_s;
  logic                    w_half;
  logic                    w_full;
  assign w_rx_s = r_sync[1];
  assign w_half = r_cnt == CW'(HALF_BIT - 1);
  assign w_full = r_cnt == CW'(CYCLES_PER_BIT - 1);
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_sync      <= 2'b11;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_shift     <= '0;
      o_rx_data   <= '0;
      o_rx_done   <= 1'b0;
      o_rx_busy   <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      r_sync      <= {r_sync[0], i_serial_data};
      o_rx_done   <= 1'b0;
      o_frame_err <= 1'b0;
      case (r_state)
        IDLE:
          if (!w_rx_s) begin
            r_cnt     <= '0;
            r_state   <= START;
            o_rx_busy <= 1'b1;
          end
        // a start bit still low at its midpoint is genuine; otherwise it was a glitch
        START:
          if (w_half) begin
            r_cnt     <= '0;
            r_idx     <= '0;
            r_state   <= w_rx_s ? IDLE : DATA;
            o_rx_busy <= !w_rx_s;
          end else r_cnt <= r_cnt + 1'b1;
        // bits arrive LSB first, so shifting in at the MSB leaves bit 0 at the LSB
        DATA:
          if (w_full) begin
            r_cnt   <= '0;
            r_shift <= {w_rx_s, r_shift[PAYLOAD_BITS-1:1]};
            r_idx   <= r_idx + 1'b1;
            if (r_idx == IW'(PAYLOAD_BITS - 1)) r_state <= STOP;
          end else r_cnt <= r_cnt + 1'b1;
        // leaving at stop-bit middle gives half a bit of slack for back-to-back frames
        STOP:
          if (w_full) begin
            r_cnt <= '0;
            if (w_rx_s) begin
              o_rx_data <= r_shift;
              o_rx_done <= 1'b1;
              o_rx_busy <= 1'b0;
              r_state   <= IDLE;
            end else begin
              o_frame_err <= 1'b1;
              r_state     <= WAIT_HIGH;
            end
          end else r_cnt <= r_cnt + 1'b1;
        // a held-low line (break) must not be mistaken for new start bits
        WAIT_HIGH:
          if (w_rx_s) begin
            o_rx_busy <= 1'b0;
            r_state   <= IDLE;
          end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed and randomized frames against a queue-based model of expected payloads
module tb_uart_rx;
  timeunit 1ns;
  timeprecision 1ps;
  localparam int BIT_NS   = 8680;
  localparam int HALF_BIT = (10_000_000 / 115200) / 2;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic [7:0] rx_data;
  logic       done;
  logic       busy;
  logic       ferr;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         done_cnt = 0;
  int         err_cnt = 0;
  int         both_cnt = 0;
  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  logic [7:0] last_good = 8'h00;
  uart_rx dut (
    .clk          (clk),
    .reset        (reset),
    .i_serial_data(rx),
    .o_rx_data    (rx_data),
    .o_rx_done    (done),
    .o_rx_busy    (busy),
    .o_frame_err  (ferr)
  );
  always #50 clk = ~clk;
  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      got.push_back(rx_data);
    end
    if (ferr) err_cnt++;
    if (done && ferr) both_cnt++;
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [7:0] d, input int bit_ns, input logic stop_bit);
    rx = 1'b0;
    #bit_ns;
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      #bit_ns;
    end
    rx = stop_bit;
    #bit_ns;
    rx = 1'b1;
    if (stop_bit) begin
      exp_q.push_back(d);
      last_good = d;
    end
  endtask
  task automatic expect_frames(input string tag, input int d0, input int e0, input int n_err);
    logic [7:0] e;
    logic [7:0] g;
    check({tag, "_done_count"}, done_cnt - d0, exp_q.size());
    check({tag, "_err_count"}, err_cnt - e0, n_err);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got.size() > 0) ? got.pop_front() : 8'hxx;
      check({tag, "_data"}, g, e);
    end
    got.delete();
    check({tag, "_hold"}, rx_data, last_good);
    check({tag, "_busy"}, busy, 1'b0);
  endtask
  initial begin
    int d0, e0;
    logic saw_busy;
    logic [7:0] b;
    repeat (4) @(negedge clk);
    check("rst_data", rx_data, 8'h00);
    check("rst_flags", {done, busy, ferr}, 3'b000);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    d0 = done_cnt; e0 = err_cnt;
    send(8'h55, BIT_NS, 1'b1);
    #(2 * BIT_NS);
    expect_frames("f55", d0, e0, 0);
    d0 = done_cnt; e0 = err_cnt;
    send(8'hA3, BIT_NS, 1'b1);
    send(8'h0F, BIT_NS, 1'b1);
    #(2 * BIT_NS);
    expect_frames("b2b", d0, e0, 0);
    d0 = done_cnt; e0 = err_cnt;
    saw_busy = 1'b0;
    @(negedge clk);
    rx = 1'b0;
    for (int i = 1; i <= HALF_BIT + 3; i++) begin
      @(negedge clk);
      if (i == 20) rx = 1'b1;
      if (busy) saw_busy = 1'b1;
    end
    check("glitch_seen", saw_busy, 1'b1);
    check("glitch_busy", busy, 1'b0);
    #(2 * BIT_NS);
    expect_frames("glitch", d0, e0, 0);
    d0 = done_cnt; e0 = err_cnt;
    send(8'h3C, BIT_NS, 1'b0);
    rx = 1'b0;
    #(5 * BIT_NS);
    rx = 1'b1;
    #(2 * BIT_NS);
    expect_frames("brk", d0, e0, 1);
    d0 = done_cnt; e0 = err_cnt;
    send(8'h81, BIT_NS, 1'b1);
    #(2 * BIT_NS);
    expect_frames("f81", d0, e0, 0);
    d0 = done_cnt; e0 = err_cnt;
    b = {4'hF, 4'($urandom_range(0, 15))};
    rx = 1'b0;
    #BIT_NS;
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      #BIT_NS;
    end
    rx = b[4];
    #(BIT_NS / 2);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_data", rx_data, 8'h00);
    check("mid_rst_flags", {done, busy, ferr}, 3'b000);
    reset = 1'b0;
    last_good = 8'h00;
    #(BIT_NS / 2);
    for (int i = 5; i < 8; i++) begin
      rx = b[i];
      #BIT_NS;
    end
    rx = 1'b1;
    #(2 * BIT_NS);
    expect_frames("rst_abandon", d0, e0, 0);
    d0 = done_cnt; e0 = err_cnt;
    send(8'hFF, BIT_NS, 1'b1);
    #(2 * BIT_NS);
    expect_frames("fFF", d0, e0, 0);
    d0 = done_cnt; e0 = err_cnt;
    send(8'h96, 8420, 1'b1);
    #(2 * BIT_NS);
    expect_frames("fast", d0, e0, 0);
    d0 = done_cnt; e0 = err_cnt;
    send(8'h96, 8940, 1'b1);
    #(2 * BIT_NS);
    expect_frames("slow", d0, e0, 0);
    for (int k = 0; k < 6; k++) begin
      d0 = done_cnt; e0 = err_cnt;
      send(8'($urandom), BIT_NS, 1'b1);
      if ($urandom_range(0, 1) == 1) send(8'($urandom), BIT_NS, 1'b1);
      #($urandom_range(1, 3) * BIT_NS);
      expect_frames("rand", d0, e0, 0);
    end
    check("done_err_overlap", both_cnt, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
